// File: rtl/lc4_fetch_queue.sv
// Instruction-fetch front end for the LC4 i1 memory port: issues sequential PCs, tracks
// requests through a fixed read latency, and buffers returned words for decode.
module lc4_fetch_queue #(
   parameter int          MEM_LATENCY = 0,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] RESET_PC    = 16'h8200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gwe,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        imem_re,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic        insn_valid,
   output logic [15:0] insn,
   output logic [15:0] insn_pc,
   input  logic        insn_ready,
   output logic        busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [15:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [15:0]   data_q [FIFO_DEPTH];
   logic [15:0]   pc_q   [FIFO_DEPTH];

   logic          advance, issue, push, pop, head_valid;
   logic          ret_valid, pipe_busy;
   logic [15:0]   ret_pc;
   logic [4:0]    inflight;

   // Credit counts only registered occupancy; a pop this cycle frees a slot next cycle.
   assign advance    = gwe & rst & ~redirect_valid;
   assign head_valid = (count_q != '0);
   assign issue      = advance & ((32'(count_q) + 32'(inflight)) < 32'(FIFO_DEPTH));
   assign push       = advance & ret_valid;
   assign pop        = advance & head_valid & insn_ready;

   if (MEM_LATENCY == 0) begin : g_direct
      assign ret_valid = issue;
      assign ret_pc    = fetch_pc_q;
      assign inflight  = '0;
      assign pipe_busy = 1'b0;
   end else begin : g_pipe
      logic [MEM_LATENCY-1:0] v_q;
      logic [15:0]            pc_pipe_q [MEM_LATENCY];

      always_ff @(posedge clk) begin
         if (!rst) begin
            v_q <= '0;
         end else if (gwe) begin
            // NOTE: non-blocking assignments make every stage read its neighbour's old value.
            v_q[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) begin
               v_q[i] <= redirect_valid ? 1'b0 : v_q[i-1];
            end
         end
      end

      // NOTE: PC datapath carries no reset; the valid bits alone decide what is real.
      always_ff @(posedge clk) begin
         if (gwe) begin
            pc_pipe_q[0] <= fetch_pc_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
               pc_pipe_q[i] <= pc_pipe_q[i-1];
            end
         end
      end

      always_comb begin
         inflight = '0;
         for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + 5'(v_q[i]);
         end
      end

      assign ret_valid = v_q[MEM_LATENCY-1];
      assign ret_pc    = pc_pipe_q[MEM_LATENCY-1];
      assign pipe_busy = |v_q;
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      if (gwe) begin
         if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
         end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 16'd1;
            if (push)  wr_d = wr_q + PW'(1);
            if (pop)   rd_d = rd_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_q] <= imem_data;
         pc_q[wr_q]   <= ret_pc;
      end
   end

   assert property (@(posedge clk) disable iff (!rst) (push && !pop) |-> (count_q < CW'(FIFO_DEPTH)));

   assign imem_re    = issue;
   assign imem_addr  = fetch_pc_q;
   assign insn_valid = rst & head_valid;
   assign insn       = insn_valid ? data_q[rd_q] : 16'h0000;
   assign insn_pc    = insn_valid ? pc_q[rd_q]   : 16'h0000;
   assign busy       = rst & pipe_busy;
endmodule
